// File: rtl/pipe_trace_tx.sv
`timescale 1ns/1ps
// Trace transmitter: buffers (PC, write-back) pairs and sends each as a 9-byte UART 8N1 frame on Tx.
// Latency: a push into an empty FIFO with the sequencer idle pops on the next edge, and Tx falls there.
// Backpressure: none upstream; a push into a full FIFO without a same-edge pop is dropped and sets Overflow.
module pipe_trace_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                     Clk,
    input  logic                     Clrn,
    input  logic                     Trace_Valid,
    input  logic [31:0]              Trace_PC,
    input  logic [31:0]              Trace_Data,
    input  logic                     Ovf_Clr,
    output logic                     Tx,
    output logic                     Busy,
    output logic                     Overflow,
    output logic [$clog2(DEPTH):0]   Fifo_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [3:0]    byte_q, byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [63:0]   frame_q, frame_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic          baud_end, last_stop, fifo_full, pop, push, drop;
    logic [7:0]    cur_byte;

    assign baud_end  = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign fifo_full = (count_q == (AW+1)'(DEPTH));
    assign last_stop = (state_q == S_STOP) && baud_end && (byte_q == 4'd8);
    assign pop       = (count_q != '0) && ((state_q == S_IDLE) || last_stop);
    assign push      = Trace_Valid && (!fifo_full || pop);
    assign drop      = Trace_Valid && fifo_full && !pop;

    // Byte 0 is the sync marker; bytes 1..8 walk the frame MSB-first.
    always_comb begin
        cur_byte = 8'hA5;
        case (byte_q)
            4'd1:    cur_byte = frame_q[63:56];
            4'd2:    cur_byte = frame_q[55:48];
            4'd3:    cur_byte = frame_q[47:40];
            4'd4:    cur_byte = frame_q[39:32];
            4'd5:    cur_byte = frame_q[31:24];
            4'd6:    cur_byte = frame_q[23:16];
            4'd7:    cur_byte = frame_q[15:8];
            4'd8:    cur_byte = frame_q[7:0];
            default: cur_byte = 8'hA5;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // A drop on the same edge as a clear must leave the flag set.
        ovf_d = drop ? 1'b1 : (Ovf_Clr ? 1'b0 : ovf_q);
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    byte_d  = 4'd0;
                    baud_d  = '0;
                    frame_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q != 4'd8) begin
                        state_d = S_START;
                        byte_d  = byte_q + 4'd1;
                        tx_d    = 1'b0;
                    end else if (pop) begin
                        state_d = S_START;
                        byte_d  = 4'd0;
                        frame_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Storage is not reset; clearing the pointers and count discards it.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {Trace_PC, Trace_Data};
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            byte_q   <= 4'd0;
            bit_q    <= 3'd0;
            baud_q   <= '0;
            frame_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            frame_q  <= frame_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Tx         = tx_q;
    assign Busy       = (state_q != S_IDLE);
    assign Overflow   = ovf_q;
    assign Fifo_Count = count_q;

endmodule

// File: tb/tb_pipe_trace_tx.sv
`timescale 1ns/1ps
// Directed bench for pipe_trace_tx: a UART monitor decodes Tx bytes with timestamps for frame checks.
module tb_pipe_trace_tx;

    localparam int C = 4;
    localparam int D = 8;

    logic        Clk, Clrn, Trace_Valid, Ovf_Clr;
    logic [31:0] Trace_PC, Trace_Data;
    logic        Tx, Busy, Overflow;
    logic [3:0]  Fifo_Count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] rx_byte [512];
    logic       rx_stop [512];
    int         rx_cyc  [512];
    int         rx_n = 0;

    int         mon_sc;
    logic [7:0] mon_b;

    pipe_trace_tx #(.DEPTH(D), .CLKS_PER_BIT(C)) dut (
        .Clk(Clk), .Clrn(Clrn), .Trace_Valid(Trace_Valid), .Trace_PC(Trace_PC),
        .Trace_Data(Trace_Data), .Ovf_Clr(Ovf_Clr), .Tx(Tx), .Busy(Busy),
        .Overflow(Overflow), .Fifo_Count(Fifo_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // UART receiver: detect start at a falling edge sample, then sample each bit one bit-time apart.
    initial begin
        forever begin
            @(negedge Clk);
            if (Clrn === 1'b1 && Tx === 1'b0) begin
                mon_sc = cyc;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge Clk);
                    mon_b[i] = Tx;
                end
                repeat (C) @(negedge Clk);
                if (rx_n < 512) begin
                    rx_byte[rx_n] = mon_b;
                    rx_stop[rx_n] = Tx;
                    rx_cyc[rx_n]  = mon_sc;
                    rx_n = rx_n + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] d, input logic clr);
        Trace_Valid = v;
        Trace_PC    = pc;
        Trace_Data  = d;
        Ovf_Clr     = clr;
        @(posedge Clk);
        #1;
        Trace_Valid = 1'b0;
        Ovf_Clr     = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (rx_n < target && k < budget) begin
            @(negedge Clk);
            k++;
        end
        chk(tag, rx_n, target);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (Busy && k < budget) begin
            @(negedge Clk);
            k++;
        end
        chk("idle_timeout", Busy, 1'b0);
    endtask

    task automatic check_frame(input int b, input logic [31:0] pc, input logic [31:0] d, input string tag);
        int bad;
        bad = 0;
        chk({tag, "_hdr"}, rx_byte[b], 8'hA5);
        chk({tag, "_pc"}, {rx_byte[b+1], rx_byte[b+2], rx_byte[b+3], rx_byte[b+4]}, pc);
        chk({tag, "_data"}, {rx_byte[b+5], rx_byte[b+6], rx_byte[b+7], rx_byte[b+8]}, d);
        for (int i = 0; i < 9; i++) if (rx_stop[b+i] !== 1'b1) bad++;
        chk({tag, "_stops"}, bad, 0);
    endtask

    initial begin
        int base, lows, bad, push_cyc;
        Clrn = 1'b0; Trace_Valid = 1'b0; Ovf_Clr = 1'b0;
        Trace_PC = '0; Trace_Data = '0;

        // Reset and idle line
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_tx", Tx, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_ovf", Overflow, 1'b0);
        chk("rst_count", Fifo_Count, 4'd0);
        Clrn = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge Clk);
            if (Tx !== 1'b1) lows++;
        end
        chk("idle_tx_low_cycles", lows, 0);
        chk("idle_busy", Busy, 1'b0);

        // Single frame
        base = rx_n;
        step(1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0);
        push_cyc = cyc;
        chk("single_count_after_push", Fifo_Count, 4'd1);
        chk("single_tx_at_push", Tx, 1'b1);
        @(negedge Clk);
        @(negedge Clk);
        chk("single_count_after_pop", Fifo_Count, 4'd0);
        chk("single_busy", Busy, 1'b1);
        wait_rx("single_rx_bytes", base + 9, 600);
        chk("single_start_delay", rx_cyc[base] - push_cyc, 1);
        check_frame(base, 32'h0000_0004, 32'h1234_5678, "single");
        wait_idle(100);
        chk("single_busy_len", cyc - rx_cyc[base], 90 * C);

        // Back-to-back
        base = rx_n;
        step(1'b1, 32'h0000_0000, 32'hC0DE_0000, 1'b0);
        chk("b2b_count1", Fifo_Count, 4'd1);
        step(1'b1, 32'h0000_0004, 32'hC0DE_0001, 1'b0);
        chk("b2b_count2", Fifo_Count, 4'd1);
        step(1'b1, 32'h0000_0008, 32'hC0DE_0002, 1'b0);
        chk("b2b_count_peak", Fifo_Count, 4'd2);
        wait_rx("b2b_rx_bytes", base + 27, 27 * 10 * C + 200);
        check_frame(base,      32'h0000_0000, 32'hC0DE_0000, "b2b0");
        check_frame(base + 9,  32'h0000_0004, 32'hC0DE_0001, "b2b1");
        check_frame(base + 18, 32'h0000_0008, 32'hC0DE_0002, "b2b2");
        bad = 0;
        for (int i = 1; i < 27; i++) if (rx_cyc[base+i] - rx_cyc[base+i-1] != 10 * C) bad++;
        chk("b2b_gap_errs", bad, 0);
        wait_idle(100);

        // Overflow, then clear priority while still full
        base = rx_n;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h0000_0100 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0);
            if (i == 8) begin
                chk("ovf_count_full", Fifo_Count, 4'd8);
                chk("ovf_before_drop", Overflow, 1'b0);
            end
        end
        chk("ovf_count_after_drop", Fifo_Count, 4'd8);
        chk("ovf_set", Overflow, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("ovf_clr_alone", Overflow, 1'b0);
        step(1'b1, 32'h0000_DEAD, 32'h0000_BEEF, 1'b1);
        chk("ovf_set_beats_clr", Overflow, 1'b1);
        chk("ovf_count_hold", Fifo_Count, 4'd8);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("ovf_clr_again", Overflow, 1'b0);
        wait_rx("ovf_rx_bytes", base + 81, 81 * 10 * C + 500);
        for (int f = 0; f < 9; f++)
            check_frame(base + 9 * f, 32'h0000_0100 + 32'(4 * f), 32'hD000_0000 + 32'(f), "ovf_frame");
        wait_idle(100);
        repeat (60) @(negedge Clk);
        chk("ovf_total_bytes", rx_n - base, 81);

        // Reset during the start bit of byte 3
        step(1'b1, 32'h0000_0200, 32'h55AA_33CC, 1'b0);
        step(1'b1, 32'h0000_0204, 32'h1111_1111, 1'b0);
        step(1'b1, 32'h0000_0208, 32'h2222_2222, 1'b0);
        repeat (119) @(posedge Clk);
        #1;
        chk("midrst_pre_tx", Tx, 1'b0);
        chk("midrst_pre_count", Fifo_Count, 4'd2);
        Clrn = 1'b0;
        #1;
        chk("midrst_tx", Tx, 1'b1);
        chk("midrst_count", Fifo_Count, 4'd0);
        chk("midrst_busy", Busy, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        Clrn = 1'b1;
        repeat (60) @(posedge Clk);
        #1;
        base = rx_n;
        step(1'b1, 32'h0000_0300, 32'h0BAD_F00D, 1'b0);
        push_cyc = cyc;
        wait_rx("post_rst_rx_bytes", base + 9, 600);
        chk("post_rst_start_delay", rx_cyc[base] - push_cyc, 1);
        check_frame(base, 32'h0000_0300, 32'h0BAD_F00D, "post_rst");
        wait_idle(100);
        repeat (60) @(negedge Clk);
        chk("post_rst_total_bytes", rx_n - base, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_trace_tx.md
# pipe_trace_tx

Trace transmitter for the pipelined CPU. It captures one (PC, write-back data) pair per retiring instruction into a small FIFO. It serialises each pair as a fixed 9-byte UART 8N1 frame on a single `Tx` line, so the write-back stream can be read off-chip on hardware instead of only through the simulation dump. It sits beside the CPU core: the CPU's write-back stage drives the trace inputs, and `Tx` goes to the board pin.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 4 — `Clk` cycles per UART bit; ≥2. Board builds override this; simulation uses 4.

- `Clk` input 1 — single clock, rising-edge.
- `Clrn` input 1 — reset, asynchronous, active-low.
- `Trace_Valid` input 1 — one instruction retires this cycle; sampled on the rising edge.
- `Trace_PC` input 32 — PC of the retiring instruction.
- `Trace_Data` input 32 — value written back (W_RegDin).
- `Ovf_Clr` input 1 — synchronous clear of `Overflow`.
- `Tx` output 1 — UART serial out; idle high.
- `Busy` output 1 — a frame is being shifted out.
- `Overflow` output 1 — sticky flag; a trace entry was dropped.
- `Fifo_Count` output log2(DEPTH)+1 — current FIFO occupancy, 0..DEPTH.

## Operation
- **FIFO:** 64-bit entries `{Trace_PC, Trace_Data}`, with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- **Push:** accepted on an edge with `Trace_Valid`=1 when `Fifo_Count`<DEPTH, or when a pop occurs on the same edge.
  - Valid with FIFO full and no pop: the entry is dropped and `Overflow` is set.
- **Pop:** occurs on an edge where the sequencer is in IDLE, or is finishing the last stop bit, and `Fifo_Count`>0.
  - The popped entry loads the frame register and `Fifo_Count` decrements.
  - A push and a pop on the same edge leave the count unchanged.
- **Frame format:** bytes in order are 0xA5, PC[31:24], PC[23:16], PC[15:8], PC[7:0], D[31:24], D[23:16], D[15:8], D[7:0].
- **Byte format:** each byte is start bit 0, then data LSB first, then stop bit 1. Bytes are sent back to back with no inter-byte gap.
- **Sequencer states:** IDLE, START, DATA, STOP. It keeps a byte index 0..8, a bit index 0..7 and a baud counter 0..CLKS_PER_BIT-1.
  - IDLE→START on pop.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP after 8 bits.
  - STOP→START with byte index +1 when byte index <8.
  - STOP→START on byte index 8 if a pop occurs (next entry, byte index 0).
  - Otherwise STOP→IDLE.
- **Outputs by state:** `Tx`=1 in IDLE and STOP, 0 in START, current data bit in DATA. `Tx` is registered.
- `Busy`=1 in every state except IDLE.
- **Overflow:** set on a drop and cleared by `Ovf_Clr`. If both happen on the same edge, set wins.
- **Reset values:** `Tx`=1, `Busy`=0, `Overflow`=0, `Fifo_Count`=0, pointers 0, state IDLE.
  - Reset mid-frame abandons the frame immediately; `Tx` returns high asynchronously and the FIFO contents are discarded.

## Timing
- **Push to start bit:** a push at edge N into an empty FIFO with the sequencer IDLE produces a pop at edge N+1, and `Tx` falls to 0 from edge N+1.
- **Per-unit durations:** each bit lasts exactly CLKS_PER_BIT cycles. One byte is 10·CLKS_PER_BIT cycles and one frame is 90·CLKS_PER_BIT cycles (360 at the default).
- **Back-to-back frames:** the next frame's start bit follows the last stop bit with no idle cycle.
- **Fill rate:** sustained retire rate above 1 per 90·CLKS_PER_BIT cycles fills the FIFO. With the FIFO holding DEPTH entries, the next push is dropped unless that edge is a pop edge.
- **Wrap-around:** pointer wrap from DEPTH-1 to 0 is seamless, and entries leave in push order.

## Test plan
1. **Reset:** hold `Clrn`=0 for 2 cycles, then release. Required: `Tx`=1, `Busy`=0, `Overflow`=0, `Fifo_Count`=0, and `Tx` stays 1 for 100 cycles with no valid input.
2. **Single frame:** one pulse with PC=0x0000_0004 and data=0x1234_5678. Required: `Tx` falls 1 cycle after the push, and the decoded bytes are A5 00 00 00 04 12 34 56 78. `Busy` drops exactly 360 cycles after it rises.
3. **Back-to-back:** 3 pulses on consecutive cycles (PC 0x0, 0x4, 0x8). Required: 3 frames in order with zero idle between them, and `Fifo_Count` peaks at 2.
4. **Overflow:** 10 consecutive pulses with default DEPTH=8. Required: `Fifo_Count` peaks at 8 after the first pop and `Overflow`=1. Exactly 9 frames are sent, for pulses 1–9 in order, and pulse 10 is dropped.
5. **Clear priority:** assert `Ovf_Clr` on the same edge as a drop. Required: `Overflow` stays 1. Then assert `Ovf_Clr` alone. Required: `Overflow`=0 on the next cycle.
6. **Reset mid-frame:** pull `Clrn` low during byte 3 of a frame. Required: `Tx`=1 immediately and `Fifo_Count`=0. After release, the next pulse produces a clean frame that starts with 0xA5.
